// File: rtl/vertex_ram_pkg.sv
// ---------------------------------------------------------------------------
// vertex_ram_pkg
// Shared types and constants for the vertex RAM and its arbiter.
//   VTX_ADDR_W / VTX_DATA_W / VTX_DEPTH : geometry of the 64x10 vertex RAM
//   vtx_rd_id_t : identity of a read requester (raster or transform stage)
//   vtx_tag_t   : one stage of the read-return tag pipeline {valid, id}
// ---------------------------------------------------------------------------
package vertex_ram_pkg;

  localparam int VTX_ADDR_W = 6;
  localparam int VTX_DATA_W = 10;
  localparam int VTX_DEPTH  = 64;

  typedef enum logic {
    RD_RASTER = 1'b0,
    RD_XFORM  = 1'b1
  } vtx_rd_id_t;

  typedef struct packed {
    logic       valid;
    vtx_rd_id_t id;
  } vtx_tag_t;

  // The requester that was not the given one; round-robin hands priority here.
  function automatic vtx_rd_id_t vtx_other_rd(input vtx_rd_id_t id);
    return (id == RD_RASTER) ? RD_XFORM : RD_RASTER;
  endfunction

endpackage

// File: rtl/vertex_rr_arb2.sv
// ---------------------------------------------------------------------------
// vertex_rr_arb2
// Two-input round-robin arbiter for the vertex RAM read port.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   req[1:0]      : read requests, bit 0 = raster, bit 1 = transform
//   block         : suppresses the grant this cycle (lock, hazard or reset)
//   winner        : requester that would be served; valid even when blocked
//   gnt[1:0]      : one-hot grant, zero when blocked or idle
// A blocked cycle leaves the priority register untouched, so a hazarded
// read keeps its turn on the retry.
// ---------------------------------------------------------------------------
module vertex_rr_arb2
  import vertex_ram_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       block,
  output vtx_rd_id_t winner,
  output logic [1:0] gnt
);

  vtx_rd_id_t last_rd_r;

  // Pick the candidate: contention goes to whoever was not served last.
  always_comb begin
    winner = RD_RASTER;
    case (req)
      2'b11:   winner = vtx_other_rd(last_rd_r);
      2'b10:   winner = RD_XFORM;
      2'b01:   winner = RD_RASTER;
      default: winner = RD_RASTER;
    endcase
  end

  // Turn the candidate into a one-hot grant unless the cycle is blocked.
  always_comb begin
    gnt = 2'b00;
    if ((|req) && !block) begin
      if (winner == RD_XFORM) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else begin
      gnt = 2'b00;
    end
  end

  // Remember who was last served; reset favours raster for the first contest.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_rd_r <= RD_XFORM;
    end else if (|gnt) begin
      last_rd_r <= winner;
    end
  end

endmodule

// File: rtl/vertex_ram_arbiter.sv
// ---------------------------------------------------------------------------
// vertex_ram_arbiter
// Shares the single-clock 64x10 vertex RAM between the vertex loader (write)
// and two readers: rd0 = line rasterizer, rd1 = transform/projection stage.
//   clock, resetn            : rising-edge clock, async active-low reset
//   wr_req/addr/data, wr_gnt : write port, never stalled
//   wr_lock                  : holds off all read grants (bulk preload)
//   rdN_req/addr, rdN_gnt    : read request handshake, gnt combinational
//   rdN_valid, rdN_data      : one-cycle return pulse, data held until next
//   ram_*                    : drives every port of vertex_ram
// A read granted in cycle t returns valid in cycle t+RD_LATENCY+1. The
// requester id travels alongside the RAM access in a tag shift register so
// the returning word lands on the right port. RD_LATENCY legal range 1..4.
// ---------------------------------------------------------------------------
module vertex_ram_arbiter
  import vertex_ram_pkg::*;
#(
  parameter int ADDR_W     = VTX_ADDR_W,
  parameter int DATA_W     = VTX_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_lock,
  output logic              wr_gnt,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd0_gnt,
  output logic              rd1_gnt,
  output logic              rd0_valid,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_q
);

  logic [1:0]        req_s;
  vtx_rd_id_t        winner_s;
  logic [1:0]        gnt_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic              block_s;
  vtx_tag_t          tag_r [RD_LATENCY];
  vtx_tag_t          tail_tag_s;

  assign req_s = {rd1_req, rd0_req};

  // Address of the would-be winner, needed for the read-during-write check.
  always_comb begin
    win_addr_s = rd0_addr;
    if (winner_s == RD_XFORM) begin
      win_addr_s = rd1_addr;
    end else begin
      win_addr_s = rd0_addr;
    end
  end

  // Reads are held off in reset, during a lock, and when they would hit the
  // address being written this same cycle (RAM read-during-write is undefined).
  always_comb begin
    block_s = (~resetn) | wr_lock | (wr_req & (win_addr_s == wr_addr));
  end

  vertex_rr_arb2 u_arb (
    .clock  (clock),
    .resetn (resetn),
    .req    (req_s),
    .block  (block_s),
    .winner (winner_s),
    .gnt    (gnt_s)
  );

  // Write path is a straight pass-through; only reset can suppress it.
  always_comb begin
    wr_gnt        = wr_req & resetn;
    ram_wren      = wr_req & resetn;
    ram_wraddress = wr_addr;
    ram_data      = wr_data;
  end

  // Read grants and RAM read address; idle cycles park on rd0's address.
  always_comb begin
    rd0_gnt = gnt_s[0];
    rd1_gnt = gnt_s[1];
    if (|gnt_s) begin
      ram_rdaddress = win_addr_s;
    end else begin
      ram_rdaddress = rd0_addr;
    end
  end

  // Tag pipeline: one stage per cycle of RAM read latency.
  for (genvar g = 0; g < RD_LATENCY; g++) begin : g_tag
    if (g == 0) begin : g_head
      // Stage 0 records whether a read was granted this cycle and to whom.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          tag_r[g] <= '{valid: 1'b0, id: RD_RASTER};
        end else begin
          tag_r[g] <= '{valid: (|gnt_s), id: winner_s};
        end
      end
    end else begin : g_body
      // Later stages simply delay the tag by one more cycle.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          tag_r[g] <= '{valid: 1'b0, id: RD_RASTER};
        end else begin
          tag_r[g] <= tag_r[g-1];
        end
      end
    end
  end

  assign tail_tag_s = tag_r[RD_LATENCY-1];

  // Capture ram_q into the port named by the tail tag and pulse its valid.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd0_valid <= 1'b0;
      rd1_valid <= 1'b0;
      rd0_data  <= {DATA_W{1'b0}};
      rd1_data  <= {DATA_W{1'b0}};
    end else begin
      rd0_valid <= tail_tag_s.valid & (tail_tag_s.id == RD_RASTER);
      rd1_valid <= tail_tag_s.valid & (tail_tag_s.id == RD_XFORM);
      if (tail_tag_s.valid && (tail_tag_s.id == RD_RASTER)) begin
        rd0_data <= ram_q;
      end
      if (tail_tag_s.valid && (tail_tag_s.id == RD_XFORM)) begin
        rd1_data <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_vertex_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vertex_ram_arbiter
// Self-checking bench: a behavioural RAM, directed scenarios and randomized
// traffic, all compared cycle by cycle against a queue-based reference model
// of the arbitration and return rules.
// ---------------------------------------------------------------------------
module tb_vertex_ram_arbiter;

  localparam int LAT = 1;

  logic       clock;
  logic       resetn;
  logic       wr_req;
  logic [5:0] wr_addr;
  logic [9:0] wr_data;
  logic       wr_lock;
  logic       wr_gnt;
  logic       rd0_req, rd1_req;
  logic [5:0] rd0_addr, rd1_addr;
  logic       rd0_gnt, rd1_gnt;
  logic       rd0_valid, rd1_valid;
  logic [9:0] rd0_data, rd1_data;
  logic [5:0] ram_wraddress, ram_rdaddress;
  logic [9:0] ram_data, ram_q;
  logic       ram_wren;

  vertex_ram_arbiter #(.ADDR_W(6), .DATA_W(10), .RD_LATENCY(LAT)) dut (
    .clock(clock), .resetn(resetn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lock(wr_lock),
    .wr_gnt(wr_gnt),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd1_req(rd1_req), .rd1_addr(rd1_addr),
    .rd0_gnt(rd0_gnt), .rd1_gnt(rd1_gnt),
    .rd0_valid(rd0_valid), .rd1_valid(rd1_valid),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural vertex RAM, single-cycle registered read.
  logic [9:0] mem [64];
  logic       preload;
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 10'(i + 100);
    end else if (ram_wren) begin
      mem[ram_wraddress] <= ram_data;
    end
    ram_q <= mem[ram_rdaddress];
  end

  // Reference model state
  typedef struct {
    int         due;
    logic       id;
    logic [9:0] data;
  } ret_t;
  ret_t       retq[$];
  logic [9:0] shadow [64];
  logic       last_m;
  logic [9:0] exp_d0, exp_d1;
  int         cyc;
  int         n_checks, n_errors;
  logic       obs_g0, obs_g1, obs_wg;
  logic       exp_g0, exp_g1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock cycle: compare mid-cycle, advance the model, move past the edge.
  task automatic step();
    logic ev0, ev1, w;
    logic [5:0] wa;
    @(negedge clock);
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (!resetn) begin
      retq.delete();
      exp_d0 = 10'd0;
      exp_d1 = 10'd0;
      last_m = 1'b1;
    end else if (retq.size() > 0 && retq[0].due == cyc) begin
      if (retq[0].id) begin ev1 = 1'b1; exp_d1 = retq[0].data; end
      else            begin ev0 = 1'b1; exp_d0 = retq[0].data; end
      void'(retq.pop_front());
    end
    if (rd0_req && rd1_req) w = ~last_m;
    else                    w = rd1_req;
    wa = w ? rd1_addr : rd0_addr;
    exp_g0 = 1'b0;
    exp_g1 = 1'b0;
    if (resetn && (rd0_req || rd1_req) && !wr_lock && !(wr_req && wa == wr_addr)) begin
      if (w) exp_g1 = 1'b1; else exp_g0 = 1'b1;
    end
    check_eq("rd0_gnt", 32'(rd0_gnt), 32'(exp_g0));
    check_eq("rd1_gnt", 32'(rd1_gnt), 32'(exp_g1));
    check_eq("wr_gnt", 32'(wr_gnt), 32'(wr_req & resetn));
    check_eq("ram_wren", 32'(ram_wren), 32'(wr_req & resetn));
    check_eq("ram_rdaddress", 32'(ram_rdaddress), 32'((exp_g0 | exp_g1) ? wa : rd0_addr));
    check_eq("rd0_valid", 32'(rd0_valid), 32'(ev0));
    check_eq("rd1_valid", 32'(rd1_valid), 32'(ev1));
    check_eq("rd0_data", 32'(rd0_data), 32'(exp_d0));
    check_eq("rd1_data", 32'(rd1_data), 32'(exp_d1));
    obs_g0 = rd0_gnt;
    obs_g1 = rd1_gnt;
    obs_wg = wr_gnt;
    if (resetn) begin
      if (exp_g0 || exp_g1) begin
        last_m = w;
        retq.push_back('{due: cyc + LAT + 1, id: w, data: shadow[wa]});
      end
      if (wr_req) shadow[wr_addr] = wr_data;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    wr_req = 1'b0; wr_lock = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  int cnt0, cnt1, gsum;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_m = 1'b1;
    exp_d0 = 10'd0; exp_d1 = 10'd0;
    for (int i = 0; i < 64; i++) shadow[i] = 10'(i + 100);
    wr_addr = 6'd0; wr_data = 10'd0; rd0_addr = 6'd0; rd1_addr = 6'd0;
    idle_inputs();
    resetn = 1'b0;
    preload = 1'b1;
    step();
    preload = 1'b0;
    step();
    resetn = 1'b1;
    step();

    // Single rd0 read of addr 3
    rd0_req = 1'b1; rd0_addr = 6'd3;
    step();
    check_eq("t1_gnt", 32'(obs_g0), 32'd1);
    rd0_req = 1'b0;
    check_eq("t1_early_valid", 32'(rd0_valid), 32'd0);
    step();
    check_eq("t1_valid", 32'(rd0_valid), 32'd1);
    check_eq("t1_data", 32'(rd0_data), 32'd103);
    check_eq("t1_rd1_valid", 32'(rd1_valid), 32'd0);

    // Continuous contention: grants must alternate
    rd0_req = 1'b1; rd0_addr = 6'd10; rd1_req = 1'b1; rd1_addr = 6'd20;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt0 += int'(obs_g0);
      cnt1 += int'(obs_g1);
    end
    check_eq("t2_rd0_grants", 32'(cnt0), 32'd3);
    check_eq("t2_rd1_grants", 32'(cnt1), 32'd3);
    idle_inputs();
    step();
    step();

    // Read-during-write hazard on addr 5
    wr_req = 1'b1; wr_addr = 6'd5; wr_data = 10'h155;
    rd1_req = 1'b1; rd1_addr = 6'd5;
    step();
    check_eq("t3_wr_gnt", 32'(obs_wg), 32'd1);
    check_eq("t3_rd1_blocked", 32'(obs_g1), 32'd0);
    wr_req = 1'b0;
    step();
    check_eq("t3_rd1_retry", 32'(obs_g1), 32'd1);
    rd1_req = 1'b0;
    step();
    check_eq("t3_rd1_data", 32'(rd1_data), 32'h155);

    // Write and read of different addresses in the same cycle
    wr_req = 1'b1; wr_addr = 6'd7; wr_data = 10'h2AA;
    rd0_req = 1'b1; rd0_addr = 6'd8;
    step();
    check_eq("t4_wr_gnt", 32'(obs_wg), 32'd1);
    check_eq("t4_rd0_gnt", 32'(obs_g0), 32'd1);
    idle_inputs();
    step();
    check_eq("t4_rd0_data", 32'(rd0_data), 32'd108);

    // Reset one cycle after a grant drops the in-flight read
    rd0_req = 1'b1; rd0_addr = 6'd4;
    step();
    check_eq("t6_gnt", 32'(obs_g0), 32'd1);
    resetn = 1'b0; rd1_req = 1'b1; wr_req = 1'b1; wr_addr = 6'd9;
    #1;
    check_eq("t6_rst_rd0_gnt", 32'(rd0_gnt), 32'd0);
    check_eq("t6_rst_rd1_gnt", 32'(rd1_gnt), 32'd0);
    check_eq("t6_rst_wr_gnt", 32'(wr_gnt), 32'd0);
    check_eq("t6_rst_wren", 32'(ram_wren), 32'd0);
    check_eq("t6_rst_data0", 32'(rd0_data), 32'd0);
    check_eq("t6_rst_data1", 32'(rd1_data), 32'd0);
    step();
    resetn = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_no_stale_valid", 32'(rd0_valid | rd1_valid), 32'd0);
    end
    rd0_req = 1'b1; rd0_addr = 6'd1; rd1_req = 1'b1; rd1_addr = 6'd2;
    step();
    check_eq("t6_rd0_priority", 32'(obs_g0), 32'd1);
    check_eq("t6_rd1_waits", 32'(obs_g1), 32'd0);
    rd0_req = 1'b0;
    step();
    rd1_req = 1'b0;
    step();
    step();

    // Bulk preload under wr_lock
    apply_reset();
    wr_lock = 1'b1;
    rd0_req = 1'b1; rd0_addr = 6'd30; rd1_req = 1'b1; rd1_addr = 6'd40;
    gsum = 0;
    for (int i = 0; i < 64; i++) begin
      wr_req = 1'b1; wr_addr = 6'(i); wr_data = 10'(i + 200);
      step();
      gsum += int'(obs_g0) + int'(obs_g1);
    end
    check_eq("t5_lock_grants", 32'(gsum), 32'd0);
    wr_lock = 1'b0; wr_req = 1'b0;
    step();
    check_eq("t5_first_rd0", 32'(obs_g0), 32'd1);
    check_eq("t5_first_rd1", 32'(obs_g1), 32'd0);
    rd0_req = 1'b0;
    step();
    check_eq("t5_then_rd1", 32'(obs_g1), 32'd1);
    check_eq("t5_rd0_data", 32'(rd0_data), 32'd230);
    rd1_req = 1'b0;
    step();
    check_eq("t5_rd1_data", 32'(rd1_data), 32'd240);

    // Randomized traffic with frequent address collisions
    for (int c = 0; c < 600; c++) begin
      if (!rd0_req || exp_g0) begin
        rd0_req = ($urandom_range(0, 2) != 0);
        rd0_addr = 6'($urandom_range(0, 7));
      end
      if (!rd1_req || exp_g1) begin
        rd1_req = ($urandom_range(0, 2) != 0);
        rd1_addr = 6'($urandom_range(0, 7));
      end
      wr_req  = ($urandom_range(0, 1) != 0);
      wr_addr = 6'($urandom_range(0, 7));
      wr_data = 10'($urandom_range(0, 1023));
      wr_lock = ($urandom_range(0, 9) == 0);
      resetn  = ($urandom_range(0, 149) != 0);
      step();
    end
    resetn = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
